// File: rtl/fifo_pkg.sv
// Shared defaults and the status bundle for the parametrised sync FIFO.
// Consumers that want every flag on one wire import fifo_status_t.
package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array for the sync FIFO.
// One synchronous write port and one asynchronous read port; never reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with simultaneous read/write, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             udf_q;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] rdata;
  fifo_status_t     st;

  always_comb begin
    st              = '0;
    st.full         = (cnt_q == CW'(DEPTH));
    st.empty        = (cnt_q == '0);
    st.almost_full  = (cnt_q >= CW'(AF_LEVEL));
    st.almost_empty = (cnt_q <= CW'(AE_LEVEL));
    st.overflow     = ovf_q;
    st.underflow    = udf_q;
  end

  assign rd_acc = rd && !st.empty;
  // a full FIFO still takes a write when a read frees a slot
  assign wr_acc = wr && (!st.full || rd_acc);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !clr),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (wr && !wr_acc) ovf_q <= 1'b1;
      if (rd && !rd_acc) udf_q <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout       = rdata;
  assign dout_valid = !st.empty;
`else
  logic [WIDTH-1:0] dout_q;
  logic             dv_q;

  // flush drops the valid strobe but keeps the last popped word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else if (clr) begin
      dv_q   <= 1'b0;
    end else begin
      dv_q <= rd_acc;
      if (rd_acc) dout_q <= rdata;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
`endif

  assign count        = cnt_q;
  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based model.
// Covers reset, fill/drain, overflow/underflow, streaming, flush, async reset.
module tb_sync_fifo_param;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         wr;
  logic [W-1:0] din;
  logic         rd;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;

  sync_fifo_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (D - 2),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q[$];
  bit           m_ovf;
  bit           m_udf;
  bit           m_dv;
  logic [W-1:0] m_dout;
  bit           popped;
  logic [W-1:0] exp_word;
  logic [W-1:0] got_word;
  int           n_checks;
  int           n_fail;

  function automatic bit exp_dv();
`ifdef SYNC_FIFO_FWFT_EN
    return q.size() > 0;
`else
    return m_dv;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_udf  = 0;
    m_dv   = 0;
    m_dout = '0;
  endtask

  task automatic cyc(input bit w, input logic [W-1:0] d,
                     input bit r, input bit c);
    bit ra;
    bit wa;
    @(negedge clk);
    wr = w; din = d; rd = r; clr = c;
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < D) || ra);
    popped = 0;
`ifdef SYNC_FIFO_FWFT_EN
    #1 got_word = dout;
`endif
    if (c) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_dv  = 0;
    end else begin
      if (ra) begin
        exp_word = q.pop_front();
        popped   = 1;
        m_dout   = exp_word;
      end
      m_dv = ra;
      if (wa) q.push_back(d);
      if (w && !wa) m_ovf = 1;
      if (r && !ra) m_udf = 1;
    end
    @(posedge clk);
    #1;
`ifndef SYNC_FIFO_FWFT_EN
    got_word = dout;
`endif
    wr = 0; rd = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clr = 0; wr = 0; rd = 0; din = '0;
    #3;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
        full !== 1'b0 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b want 0 1 1 0 0",
               count, empty, almost_empty, full, almost_full);
    end
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got ovf=%b udf=%b dv=%b want 0 0 0",
               overflow, underflow, dout_valid);
    end
`ifndef SYNC_FIFO_FWFT_EN
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout: got %h want 00", dout);
    end
`endif
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      cyc(1, 8'(i), 0, 0);
      n_checks++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14)) begin
        n_fail++;
        $display("FAIL fill_%0d: got cnt=%0d af=%b want %0d %b",
                 i, count, almost_full, i + 1, (i + 1 >= 14));
      end
    end
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_full: got f=%b cnt=%0d want 1 16", full, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      cyc(0, '0, 1, 0);
      n_checks++;
      if (got_word !== 8'(i) || dout_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_%0d: got %h dv=%b want %h 1",
                 i, got_word, dout_valid, 8'(i));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_end: got e=%b udf=%b want 1 0", empty, underflow);
    end
    cyc(0, '0, 0, 0);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_dv_low: got %b want 0", dout_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_reject: got ovf=%b cnt=%0d want 1 16", overflow, count);
    end
    cyc(1, 8'hBB, 1, 0);
    n_checks++;
    if (count !== 5'd16 || !popped || got_word !== exp_word) begin
      n_fail++;
      $display("FAIL ovf_wrrd: got cnt=%0d d=%h want 16 %h",
               count, got_word, exp_word);
    end
    for (int i = 0; i < D; i++) begin
      cyc(0, '0, 1, 0);
      n_checks++;
      if (got_word !== exp_word) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d: got %h want %h", i, got_word, exp_word);
      end
    end
    n_checks++;
    if (got_word !== 8'hBB) begin
      n_fail++;
      $display("FAIL ovf_last: got %h want bb", got_word);
    end
  endtask

  task automatic test_empty_wrrd();
    cyc(0, '0, 0, 1);
    cyc(1, 8'h55, 1, 0);
    n_checks++;
    if (count !== 5'd1 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_wrrd: got cnt=%0d udf=%b want 1 1", count, underflow);
    end
    cyc(0, '0, 1, 0);
    n_checks++;
    if (got_word !== 8'h55) begin
      n_fail++;
      $display("FAIL empty_read: got %h want 55", got_word);
    end
  endtask

  task automatic test_stream();
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'($urandom), 1, 0);
      n_checks++;
      if (count !== 5'd5 || got_word !== exp_word) begin
        n_fail++;
        $display("FAIL stream_%0d: got cnt=%0d d=%h want 5 %h",
                 i, count, got_word, exp_word);
      end
    end
  endtask

  task automatic test_clr();
    cyc(0, '0, 0, 1);
    for (int i = 0; i <= D; i++) cyc(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, '0, 1, 0);
    n_checks++;
    if (count !== 5'd9 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre: got cnt=%0d ovf=%b want 9 1", count, overflow);
    end
    cyc(1, 8'h77, 0, 1);
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 ||
        dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr: got cnt=%0d e=%b ovf=%b dv=%b want 0 1 0 0",
               count, empty, overflow, dout_valid);
    end
    cyc(1, 8'h66, 0, 0);
    cyc(0, '0, 1, 0);
    n_checks++;
    if (got_word !== 8'h66 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL clr_discard: got %h cnt=%0d want 66 0", got_word, count);
    end
  endtask

  task automatic test_random();
    int wp;
    int rp;
    wp = 50; rp = 50;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        wp = $urandom_range(20, 90);
        rp = 110 - wp;
      end
      cyc($urandom_range(0, 99) < wp, 8'($urandom),
          $urandom_range(0, 99) < rp, $urandom_range(0, 59) == 0);
      n_checks++;
      if (count !== 5'(q.size()) || full !== (q.size() == D) ||
          empty !== (q.size() == 0) || almost_full !== (q.size() >= D - 2) ||
          almost_empty !== (q.size() <= 2)) begin
        n_fail++;
        $display("FAIL rand_occ_%0d: got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d",
                 i, count, full, empty, almost_full, almost_empty, q.size());
      end
      n_checks++;
      if (overflow !== m_ovf || underflow !== m_udf ||
          dout_valid !== exp_dv()) begin
        n_fail++;
        $display("FAIL rand_err_%0d: got ovf=%b udf=%b dv=%b want %b %b %b",
                 i, overflow, underflow, dout_valid, m_ovf, m_udf, exp_dv());
      end
      if (popped) begin
        n_checks++;
        if (got_word !== exp_word) begin
          n_fail++;
          $display("FAIL rand_data_%0d: got %h want %h", i, got_word, exp_word);
        end
      end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (dout !== m_dout) begin
        n_fail++;
        $display("FAIL rand_hold_%0d: got %h want %h", i, dout, m_dout);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 8'($urandom), 1, 0);
    @(negedge clk);
    wr = 1; din = 8'h3C;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
        full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got cnt=%0d e=%b ae=%b f=%b af=%b ovf=%b udf=%b dv=%b",
               count, empty, almost_empty, full, almost_full,
               overflow, underflow, dout_valid);
    end
`ifndef SYNC_FIFO_FWFT_EN
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst_dout: got %h want 00", dout);
    end
`endif
    wr = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    cyc(1, 8'h5A, 0, 0);
    cyc(0, '0, 1, 0);
    n_checks++;
    if (got_word !== 8'h5A || count !== 5'd0) begin
      n_fail++;
      $display("FAIL async_after: got %h cnt=%0d want 5a 0", got_word, count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_empty_wrrd();
    test_stream();
    test_clr();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
